core_psum_accum: RTL and testbench

//  Parametrised partial-sum accumulation and drain stage behind pe_array inside the core.

---
 rtl/core_psum_accum.sv | 199 +++++++++++++++++++
 tb/tb_core_psum_accum.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_psum_accum.sv
// Partial-sum accumulator: per-column banks written by pe_array, drained column-major through a requantiser.
// Optional build macro PSUM_RELU_EN clamps negative requantised results to zero before saturation.
module core_psum_accum #(
   parameter int NUM_COLS  = 32,
   parameter int ADDR_PSUM = 12,
   parameter int DEPTH     = 64,
   parameter int PSUM_BW   = 32,
   parameter int OUT_BW    = 8,
   localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
   localparam int DW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          start,
   input  logic                          first_pass,
   input  logic                          last_pass,
   input  logic [ADDR_PSUM-1:0]          drain_len,
   input  logic [4:0]                    shift,
   input  logic [NUM_COLS-1:0]           psum_valids,
   input  logic [ADDR_PSUM*NUM_COLS-1:0] psum_addrs,
   input  logic [PSUM_BW*NUM_COLS-1:0]   psum_rows,
   input  logic                          in_done,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [OUT_BW-1:0]             out_data,
   output logic [CW-1:0]                 out_col,
   output logic [ADDR_PSUM-1:0]          out_addr,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_FIN} state_t;

   localparam logic [ADDR_PSUM:0]   DEPTH_W  = (ADDR_PSUM+1)'(DEPTH);
   localparam logic [ADDR_PSUM-1:0] DEPTH_M1 = ADDR_PSUM'(DEPTH - 1);
   localparam logic signed [PSUM_BW:0] QMAX = (PSUM_BW+1)'((64'd1 << (OUT_BW-1)) - 64'd1);
   localparam logic signed [PSUM_BW:0] QMIN = -QMAX - 1;

   state_t r_state, w_next;

   logic                          r_first, r_last;
   logic [4:0]                    r_shift;
   logic [ADDR_PSUM-1:0]          r_last_addr;
   logic                          r_err;

   logic [CW-1:0]                 r_rd_col;
   logic [ADDR_PSUM-1:0]          r_rd_addr;
   logic                          r_more;
   logic                          r_out_valid, r_out_last;
   logic [OUT_BW-1:0]             r_out_data;
   logic [CW-1:0]                 r_out_col;
   logic [ADDR_PSUM-1:0]          r_out_addr;

   logic [NUM_COLS-1:0]               w_bad, w_ovf;
   logic [NUM_COLS-1:0][PSUM_BW-1:0]  w_col_rd;
   logic                              w_accum, w_go, w_load, w_accept;
   logic                              w_col_end, w_rd_last;
   logic [ADDR_PSUM-1:0]              w_dlen_m1;

   assign w_accum = (r_state == S_ACCUM);
   assign w_go    = (r_state == S_IDLE) && start;

   // One bank per column; read-modify-write in a single cycle so consecutive hits accumulate.
   for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      logic [PSUM_BW-1:0]   r_mem [DEPTH];
      logic [ADDR_PSUM-1:0] w_addr;
      logic [PSUM_BW-1:0]   w_d, w_old, w_sum, w_new;
      logic                 w_inrange, w_wr;

      assign w_addr    = psum_addrs[ADDR_PSUM*c +: ADDR_PSUM];
      assign w_d       = psum_rows[PSUM_BW*c +: PSUM_BW];
      assign w_inrange = ({1'b0, w_addr} < DEPTH_W);
      assign w_old     = r_mem[w_addr[DW-1:0]];
      assign w_sum     = w_old + w_d;
      assign w_new     = r_first ? w_d : w_sum;
      assign w_wr      = psum_valids[c] && w_accum && w_inrange;
      assign w_bad[c]  = psum_valids[c] && (!w_accum || !w_inrange);
      assign w_ovf[c]  = w_wr && !r_first && (w_old[PSUM_BW-1] == w_d[PSUM_BW-1])
                         && (w_sum[PSUM_BW-1] != w_old[PSUM_BW-1]);
      assign w_col_rd[c] = r_mem[r_rd_addr[DW-1:0]];

      always_ff @(posedge clk) begin
         if (w_wr) r_mem[w_addr[DW-1:0]] <= w_new;
      end
   end

   // Requantise the word under the drain pointer: round-half-up, arithmetic shift, then saturate.
   logic [PSUM_BW-1:0]        w_rd_word;
   logic signed [PSUM_BW:0]   w_ext, w_rnd, w_rsum, w_shr, w_pre;
   logic [OUT_BW-1:0]         w_q;

   assign w_rd_word = w_col_rd[r_rd_col];

   always_comb begin
      w_ext  = {w_rd_word[PSUM_BW-1], w_rd_word};
      w_rnd  = '0;
      if (r_shift != 5'd0) w_rnd = (PSUM_BW+1)'(1) << (r_shift - 5'd1);
      w_rsum = w_ext + w_rnd;
      w_shr  = w_rsum >>> r_shift;
`ifdef PSUM_RELU_EN
      w_pre  = (w_shr < 0) ? '0 : w_shr;
`else
      w_pre  = w_shr;
`endif
      if (w_pre > QMAX)      w_q = QMAX[OUT_BW-1:0];
      else if (w_pre < QMIN) w_q = QMIN[OUT_BW-1:0];
      else                   w_q = w_pre[OUT_BW-1:0];
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_ACCUM;
         S_ACCUM: if (in_done) w_next = r_last ? S_DRAIN : S_FIN;
         S_DRAIN: if (r_out_valid && out_ready && r_out_last) w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // drain_len of 0 behaves as 1, anything past the bank is clamped to the bank depth
   always_comb begin
      if (drain_len == '0)                 w_dlen_m1 = '0;
      else if ({1'b0, drain_len} > DEPTH_W) w_dlen_m1 = DEPTH_M1;
      else                                  w_dlen_m1 = drain_len - 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_first     <= 1'b0;
         r_last      <= 1'b0;
         r_shift     <= '0;
         r_last_addr <= '0;
      end else if (w_go) begin
         r_first     <= first_pass;
         r_last      <= last_pass;
         r_shift     <= shift;
         r_last_addr <= w_dlen_m1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_err <= 1'b0;
      else         r_err <= (w_go ? 1'b0 : r_err) | (|w_bad) | (|w_ovf);
   end

   assign w_accept  = r_out_valid && out_ready;
   assign w_load    = (r_state == S_DRAIN) && r_more && (!r_out_valid || out_ready);
   assign w_col_end = (r_rd_addr == r_last_addr);
   assign w_rd_last = w_col_end && (r_rd_col == CW'(NUM_COLS - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rd_col    <= '0;
         r_rd_addr   <= '0;
         r_more      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
         r_out_col   <= '0;
         r_out_addr  <= '0;
      end else if (w_accum && in_done && r_last) begin
         r_rd_col  <= '0;
         r_rd_addr <= '0;
         r_more    <= 1'b1;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_q;
         r_out_col   <= r_rd_col;
         r_out_addr  <= r_rd_addr;
         r_out_last  <= w_rd_last;
         if (w_rd_last) begin
            r_more <= 1'b0;
         end else if (w_col_end) begin
            r_rd_col  <= r_rd_col + 1'b1;
            r_rd_addr <= '0;
         end else begin
            r_rd_addr <= r_rd_addr + 1'b1;
         end
      end else if (w_accept) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_col   = r_out_col;
   assign out_addr  = r_out_addr;
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_FIN);
   assign err       = r_err;

endmodule

// File: tb/tb_core_psum_accum.sv
// Directed bench for core_psum_accum: overwrite/accumulate passes, requant corners, drain handshake, errors.
module tb_core_psum_accum;
   localparam int NC = 32, AP = 12, PB = 32, OB = 8, CW = 5;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              start = 1'b0, first_pass = 1'b0, last_pass = 1'b0;
   logic [AP-1:0]     drain_len = '0;
   logic [4:0]        shift = '0;
   logic [NC-1:0]     psum_valids = '0;
   logic [AP*NC-1:0]  psum_addrs = '0;
   logic [PB*NC-1:0]  psum_rows = '0;
   logic              in_done = 1'b0;
   logic              out_valid, out_ready = 1'b1;
   logic [OB-1:0]     out_data;
   logic [CW-1:0]     out_col;
   logic [AP-1:0]     out_addr;
   logic              busy, done, err;

   int n_tests = 0, n_fail = 0;
   logic [OB-1:0] cap_data [512];
   logic [CW-1:0] cap_col  [512];
   logic [AP-1:0] cap_addr [512];

   core_psum_accum #(.NUM_COLS(NC), .ADDR_PSUM(AP), .DEPTH(64), .PSUM_BW(PB), .OUT_BW(OB)) dut (
      .clk(clk), .resetn(resetn), .start(start), .first_pass(first_pass), .last_pass(last_pass),
      .drain_len(drain_len), .shift(shift), .psum_valids(psum_valids), .psum_addrs(psum_addrs),
      .psum_rows(psum_rows), .in_done(in_done), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_col(out_col), .out_addr(out_addr), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic begin_pass(input logic f, input logic l, input int dl, input int sh);
      start = 1'b1; first_pass = f; last_pass = l; drain_len = dl[AP-1:0]; shift = sh[4:0];
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic set_lane(input int c, input int a, input logic [PB-1:0] d);
      psum_valids[c]        = 1'b1;
      psum_addrs[AP*c +: AP] = a[AP-1:0];
      psum_rows[PB*c +: PB]  = d;
   endtask

   task automatic wr(input int c, input int a, input logic [PB-1:0] d);
      set_lane(c, a, d);
      @(negedge clk);
      psum_valids = '0;
   endtask

   task automatic pulse_in_done();
      in_done = 1'b1;
      @(negedge clk);
      in_done = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         if (done) seen = 1;
         else @(negedge clk);
      end
      chk(tag, seen, 1);
      @(negedge clk);
   endtask

   // Collect a full drain; optionally stall every other cycle and verify held outputs.
   task automatic run_drain(input string tag, input bit toggle, input int dl);
      int n = 0, cyc = 0, ord_err = 0;
      bit seen_done = 0, prev_stall = 0;
      logic [OB-1:0] pd; logic [CW-1:0] pc; logic [AP-1:0] pa;
      while (!seen_done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (done) seen_done = 1;
         if (prev_stall)
            chk({tag, "_hold"}, {out_valid, out_data, out_col, out_addr}, {1'b1, pd, pc, pa});
         out_ready = toggle ? cyc[0] : 1'b1;
         if (out_valid && out_ready && n < 512) begin
            cap_data[n] = out_data; cap_col[n] = out_col; cap_addr[n] = out_addr; n++;
         end
         prev_stall = out_valid && !out_ready;
         pd = out_data; pc = out_col; pa = out_addr;
      end
      out_ready = 1'b1;
      chk({tag, "_done"}, seen_done, 1);
      chk({tag, "_words"}, n, NC * dl);
      for (int i = 0; i < n; i++)
         if (int'(cap_col[i]) != i / dl || int'(cap_addr[i]) != i % dl) ord_err++;
      chk({tag, "_order"}, ord_err, 0);
      @(negedge clk);
      chk({tag, "_done_1cyc"}, done, 0);
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      bit seen;
      repeat (3) @(negedge clk);
      chk("rst_valid", out_valid, 0); chk("rst_data", out_data, 0); chk("rst_col", out_col, 0);
      chk("rst_addr", out_addr, 0);   chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      resetn = 1'b1;
      @(negedge clk);

      // 1: overwrite pass, two words per column, shift 0
      begin_pass(1, 1, 2, 0);
      chk("t1_busy", busy, 1);
      wr(0, 0, 32'd5);
      wr(0, 1, -32'sd3);
      pulse_in_done();
      chk("t1_first_lat", out_valid, 0);
      run_drain("t1", 0, 2);
      chk("t1_d00", cap_data[0], 8'd5);
      chk("t1_d01", cap_data[1], 8'hFD);
      chk("t1_err", err, 0);

      // 2: accumulate across passes with rounding shift: (100+28+2)>>2 = 32
      begin_pass(1, 0, 1, 0);
      wr(3, 7, 32'd100);
      pulse_in_done();
      wait_done("t2_p1_done");
      begin_pass(0, 1, 8, 2);
      wr(3, 7, 32'd28);
      pulse_in_done();
      run_drain("t2", 0, 8);
      chk("t2_c3a7", cap_data[3*8+7], 8'd32);

      // 3: three back-to-back +10 hits on one address, then in_done with no gap
      begin_pass(1, 0, 1, 0);
      wr(5, 2, 32'd0);
      pulse_in_done();
      wait_done("t3_p1_done");
      begin_pass(0, 1, 3, 0);
      set_lane(5, 2, 32'd10);
      repeat (2) @(negedge clk);
      in_done = 1'b1;
      @(negedge clk);
      in_done = 1'b0; psum_valids = '0;
      run_drain("t3", 0, 3);
      chk("t3_acc30", cap_data[5*3+2], 8'd30);

      // 4: saturation and rounding
      begin_pass(1, 1, 2, 0);
      wr(1, 0, 32'd1000);
      wr(1, 1, -32'sd1000);
      pulse_in_done();
      run_drain("t4a", 0, 2);
      chk("t4_sat_pos", cap_data[2], 8'h7F);
`ifdef PSUM_RELU_EN
      chk("t4_sat_neg", cap_data[3], 8'h00);
`else
      chk("t4_sat_neg", cap_data[3], 8'h80);
`endif
      begin_pass(1, 1, 1, 2);
      set_lane(0, 0, 32'd6); set_lane(1, 0, -32'sd6); set_lane(2, 0, 32'd5);
      @(negedge clk);
      psum_valids = '0;
      pulse_in_done();
      run_drain("t4b", 0, 1);
      chk("t4_rnd6", cap_data[0], 8'd2);
`ifdef PSUM_RELU_EN
      chk("t4_rndm6", cap_data[1], 8'h00);
`else
      chk("t4_rndm6", cap_data[1], 8'hFF);
`endif
      chk("t4_rnd5", cap_data[2], 8'd1);

      // 5: back-pressure toggling
      begin_pass(1, 1, 2, 0);
      wr(7, 0, 32'd77);
      wr(7, 1, -32'sd77);
      pulse_in_done();
      run_drain("t5", 1, 2);
      chk("t5_c7a0", cap_data[14], 8'd77);
      chk("t5_c7a1", cap_data[15], 8'hB3);

      // 6: error cases
      begin_pass(1, 0, 1, 0);
      wr(4, 0, 32'd11);
      chk("t6_err_clean", err, 0);
      wr(4, 64, 32'd999);
      chk("t6_err_range", err, 1);
      pulse_in_done();
      wait_done("t6_p1_done");
      chk("t6_err_sticky", err, 1);
      begin_pass(0, 0, 1, 0);
      chk("t6_err_clr", err, 0);
      pulse_in_done();
      wait_done("t6_p2_done");
      wr(4, 0, 32'd500);
      chk("t6_err_idle", err, 1);
      begin_pass(0, 1, 1, 0);
      pulse_in_done();
      run_drain("t6", 0, 1);
      chk("t6_bank_kept", cap_data[4], 8'd11);
      chk("t6_err_after", err, 0);
      begin_pass(1, 0, 1, 0);
      wr(6, 0, 32'h7FFF_FFFF);
      pulse_in_done();
      wait_done("t6_p3_done");
      begin_pass(0, 0, 1, 0);
      wr(6, 0, 32'd1);
      chk("t6_err_ovf", err, 1);
      pulse_in_done();
      wait_done("t6_p4_done");

      // reset in the middle of a stalled drain
      begin_pass(1, 1, 2, 0);
      wr(0, 0, 32'd1);
      out_ready = 1'b0;
      pulse_in_done();
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (out_valid) seen = 1;
         else @(negedge clk);
      end
      chk("t7_valid_seen", seen, 1);
      resetn = 1'b0;
      #1;
      chk("t7_rst_valid", out_valid, 0); chk("t7_rst_busy", busy, 0);
      chk("t7_rst_data", out_data, 0);   chk("t7_rst_err", err, 0);
      @(negedge clk);
      resetn = 1'b1; out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done || busy) seen = 1;
      end
      chk("t7_no_done", seen, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
